// File: rtl/fft_dif_butterfly.sv
// rtl/fft_dif_butterfly.sv - radix-2 DIF butterfly X=A+B, Y=(A-B)*W, 4-rank pipeline, valid/ready
module fft_dif_butterfly #(
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int SCALE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] Ar,
  input  logic [DW-1:0] Ai,
  input  logic [DW-1:0] Br,
  input  logic [DW-1:0] Bi,
  input  logic [TW-1:0] Wr,
  input  logic [TW-1:0] Wi,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Xr,
  output logic [DW-1:0] Xi,
  output logic [DW-1:0] Yr,
  output logic [DW-1:0] Yi,
  output logic          sat_flag,
  input  logic          sat_clear
);

  localparam int SW = DW + 1;
  localparam int PW = DW + TW + 1;
  localparam int YW = DW + TW + 2;
  localparam int RW = YW + 1;
  localparam int SH = TW - 2 + SCALE;
  localparam logic signed [RW-1:0] RND  = RW'(1) <<< (SH - 1);
  localparam logic signed [RW-1:0] MAXV = RW'((2 ** (DW - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  logic                 s1_valid, s2_valid, s3_valid;
  logic signed [SW-1:0] s1_sr, s1_si, s1_dr, s1_di;
  logic signed [TW-1:0] s1_wr, s1_wi;
  logic signed [SW-1:0] s2_sr, s2_si;
  logic signed [PW-1:0] s2_pa, s2_pb, s2_pc, s2_pd;
  logic signed [SW-1:0] s3_sr, s3_si;
  logic signed [YW-1:0] s3_yr, s3_yi;

  // Valids reset; data ranks only need to advance together with them.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && adv) begin
      s1_sr <= $signed({Ar[DW-1], Ar}) + $signed({Br[DW-1], Br});
      s1_si <= $signed({Ai[DW-1], Ai}) + $signed({Bi[DW-1], Bi});
      s1_dr <= $signed({Ar[DW-1], Ar}) - $signed({Br[DW-1], Br});
      s1_di <= $signed({Ai[DW-1], Ai}) - $signed({Bi[DW-1], Bi});
      s1_wr <= $signed(Wr);
      s1_wi <= $signed(Wi);

      s2_sr <= s1_sr;
      s2_si <= s1_si;
      s2_pa <= PW'(s1_dr) * PW'(s1_wr);
      s2_pb <= PW'(s1_di) * PW'(s1_wi);
      s2_pc <= PW'(s1_dr) * PW'(s1_wi);
      s2_pd <= PW'(s1_di) * PW'(s1_wr);

      s3_sr <= s2_sr;
      s3_si <= s2_si;
      s3_yr <= YW'(s2_pa) - YW'(s2_pb);
      s3_yi <= YW'(s2_pc) + YW'(s2_pd);
    end
  end

  // Returns {saturated, value} clamped to the DW-bit signed range.
  function automatic logic [DW:0] sat(input logic signed [RW-1:0] v);
    if (v > MAXV)      sat = {1'b1, MAXV[DW-1:0]};
    else if (v < MINV) sat = {1'b1, MINV[DW-1:0]};
    else               sat = {1'b0, v[DW-1:0]};
  endfunction

  logic signed [RW-1:0] xr_w, xi_w, yr_w, yi_w;
  logic [DW:0]          xr_s, xi_s, yr_s, yi_s;
  logic                 any_sat;

  assign yr_w = (RW'(s3_yr) + RND) >>> SH;
  assign yi_w = (RW'(s3_yi) + RND) >>> SH;
  assign xr_w = (SCALE != 0) ? ((RW'(s3_sr) + RW'(1)) >>> 1) : RW'(s3_sr);
  assign xi_w = (SCALE != 0) ? ((RW'(s3_si) + RW'(1)) >>> 1) : RW'(s3_si);

  assign xr_s    = sat(xr_w);
  assign xi_s    = sat(xi_w);
  assign yr_s    = sat(yr_w);
  assign yi_s    = sat(yi_w);
  assign any_sat = xr_s[DW] | xi_s[DW] | yr_s[DW] | yi_s[DW];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      Xr        <= '0;
      Xi        <= '0;
      Yr        <= '0;
      Yi        <= '0;
    end else if (adv) begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        Xr <= xr_s[DW-1:0];
        Xi <= xi_s[DW-1:0];
        Yr <= yr_s[DW-1:0];
        Yi <= yi_s[DW-1:0];
      end
    end
  end

  // A new saturation beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)                          sat_flag <= 1'b0;
    else if (adv && s3_valid && any_sat) sat_flag <= 1'b1;
    else if (sat_clear)                 sat_flag <= 1'b0;
  end

endmodule
